// File: rtl/im_data_fetcher.sv
// Streams item words from memory into the item memory: issues credit-limited
// reads, buffers in-order responses and hands them out over a valid/ready port.
module im_data_fetcher #(
    parameter int HVDimension  = 512,
    parameter int ImAddrWidth  = 10,
    parameter int MemAddrWidth = 32,
    parameter int BufDepth     = 2,
    parameter int CntWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [MemAddrWidth-1:0] cfg_base_addr_i,
    input  logic [CntWidth-1:0]     cfg_num_items_i,
    input  logic                    cfg_highdim_i,
    input  logic                    start_i,
    input  logic                    clr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [MemAddrWidth-1:0] mem_req_addr_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    input  logic [HVDimension-1:0]  mem_rsp_data_i,
    input  logic                    mem_rsp_valid_i,
    output logic [ImAddrWidth-1:0]  lowdim_data_o,
    output logic [HVDimension-1:0]  highdim_data_o,
    output logic                    data_valid_o,
    input  logic                    data_ready_i
);
    localparam int CW = $clog2(BufDepth + 1);
    localparam int PW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam logic [MemAddrWidth-1:0] ADDR_STEP = MemAddrWidth'(HVDimension / 8);
    localparam logic [PW-1:0] PTR_LAST = PW'(BufDepth - 1);
    localparam logic [CW:0] DEPTH = (CW + 1)'(BufDepth);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
    state_e r_state, w_state_nxt;

    logic [MemAddrWidth-1:0] r_addr;
    logic [CntWidth-1:0]     r_num, r_issued, r_delivered;
    logic                    r_highdim, r_done, w_done_nxt;
    logic [CW-1:0]           r_inflight, r_discard, r_buf_count;
    logic [CW-1:0]           w_outstanding, w_clr_discard;
    logic [PW-1:0]           r_wptr, r_rptr;
    logic [HVDimension-1:0]  r_buf [BufDepth];
    logic [HVDimension-1:0]  w_head;
    logic w_start, w_req_fire, w_rsp_take, w_rsp_drop, w_rd;
    logic w_last_req, w_last_rd, w_credit, w_unused_hd;

    // Credit uses registered counts only: a slot freed this cycle is reusable next cycle.
    assign w_credit        = ({1'b0, r_inflight} + {1'b0, r_buf_count}) < DEPTH;
    assign mem_req_valid_o = !rst_i && !clr_i && (r_state == FETCH) && w_credit;
    assign mem_req_addr_o  = r_addr;
    assign busy_o          = !rst_i && (r_state != IDLE);
    assign done_o          = r_done;

    assign w_start    = start_i && !clr_i && (r_state == IDLE) && (r_discard == '0);
    assign w_req_fire = mem_req_valid_o && mem_req_ready_i;
    assign w_last_req = (r_issued == r_num - CntWidth'(1));
    // Beats with nothing tracked (e.g. issued before a reset) are dropped.
    assign w_rsp_take = mem_rsp_valid_i && !clr_i && (r_discard == '0) && (r_inflight != '0);
    assign w_rsp_drop = mem_rsp_valid_i && (r_discard != '0);

    assign data_valid_o   = !rst_i && (r_buf_count != '0);
    assign w_head         = r_buf[r_rptr];
    assign lowdim_data_o  = data_valid_o ? w_head[ImAddrWidth-1:0] : '0;
    assign highdim_data_o = data_valid_o ? w_head : '0;
    assign w_rd           = data_valid_o && data_ready_i && !clr_i;
    assign w_last_rd      = w_rd && (r_delivered == r_num - CntWidth'(1));

    // A beat landing in the clear cycle itself already retires one outstanding read.
    assign w_outstanding = r_inflight + r_discard;
    assign w_clr_discard = w_outstanding - CW'(mem_rsp_valid_i && (w_outstanding != '0));
    assign w_unused_hd   = r_highdim;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (cfg_num_items_i != '0) w_state_nxt = FETCH;
                    else                       w_done_nxt  = 1'b1;
                end
            end
            FETCH: if (w_req_fire && w_last_req) w_state_nxt = DRAIN;
            DRAIN: begin
                if (w_last_rd) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clr_i) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_num       <= '0;
            r_highdim   <= 1'b0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_inflight  <= '0;
            r_discard   <= '0;
            r_buf_count <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else if (clr_i) begin
            r_issued    <= '0;
            r_delivered <= '0;
            r_inflight  <= '0;
            r_discard   <= w_clr_discard;
            r_buf_count <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            if (w_start) begin
                r_addr      <= cfg_base_addr_i;
                r_num       <= cfg_num_items_i;
                r_highdim   <= cfg_highdim_i;
                r_issued    <= '0;
                r_delivered <= '0;
            end else if (w_req_fire) begin
                r_addr   <= r_addr + ADDR_STEP;
                r_issued <= r_issued + CntWidth'(1);
            end
            r_inflight  <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);
            r_buf_count <= r_buf_count + CW'(w_rsp_take) - CW'(w_rd);
            if (w_rsp_drop) r_discard <= r_discard - CW'(1);
            if (w_rsp_take) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
            if (w_rd) begin
                r_rptr      <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
                r_delivered <= r_delivered + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_rsp_take) r_buf[r_wptr] <= mem_rsp_data_i;
    end
endmodule

// File: tb/tb_im_data_fetcher.sv
// Directed + randomized bench for im_data_fetcher with a latency-modelled
// memory and an address-derived expected-data model.
module tb_im_data_fetcher;
    logic         clk;
    logic         rst_i, start_i, clr_i, cfg_highdim_i;
    logic [31:0]  cfg_base_addr_i;
    logic [15:0]  cfg_num_items_i;
    logic         busy_o, done_o, mem_req_valid_o, mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic [511:0] mem_rsp_data_i, highdim_data_o;
    logic         mem_rsp_valid_i, data_valid_o, data_ready_i;
    logic [9:0]   lowdim_data_o;

    im_data_fetcher dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_base_addr_i(cfg_base_addr_i), .cfg_num_items_i(cfg_num_items_i),
        .cfg_highdim_i(cfg_highdim_i), .start_i(start_i), .clr_i(clr_i),
        .busy_o(busy_o), .done_o(done_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_valid_i(mem_rsp_valid_i),
        .lowdim_data_o(lowdim_data_o), .highdim_data_o(highdim_data_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int lat = 1, rq_mode = 1, dr_mode = 1;
    bit ovr_en = 1'b0;

    // Memory contents: a hash of the word address; optional 0xABC in the low bits.
    function automatic logic [511:0] mem_word(input logic [31:0] a, input bit ovr);
        logic [511:0] w;
        logic [31:0]  x;
        for (int i = 0; i < 16; i++) begin
            x = (a + 32'(i)) * 32'h9E37_79B1;
            w[32*i +: 32] = x ^ (x >> 15);
        end
        if (ovr) w[11:0] = 12'hABC;
        return w;
    endfunction

    // Bus observer: logs request/output handshakes and protocol violations.
    logic [31:0]  req_q[$];
    int           due_q[$];
    bit           ovr_q[$];
    logic [511:0] hd_q[$];
    logic [9:0]   ld_q[$];
    int cyc = 0, last_due = 0, mon_due, done_cnt = 0, dbl_done = 0, stall_viol = 0;
    bit prev_done = 0, dv_stall = 0, rq_stall = 0;
    logic [511:0] stall_hd;
    logic [9:0]   stall_ld;
    logic [31:0]  stall_addr;

    always @(posedge clk) begin
        if (mem_req_valid_o && mem_req_ready_i) begin
            mon_due = cyc + lat;
            if (mon_due <= last_due) mon_due = last_due + 1;
            last_due = mon_due;
            req_q.push_back(mem_req_addr_o);
            due_q.push_back(mon_due);
            ovr_q.push_back(ovr_en);
        end
        if (data_valid_o && data_ready_i) begin
            hd_q.push_back(highdim_data_o);
            ld_q.push_back(lowdim_data_o);
        end
        if (!rst_i && !clr_i) begin
            if (dv_stall && !(data_valid_o === 1'b1 && highdim_data_o === stall_hd &&
                              lowdim_data_o === stall_ld)) stall_viol++;
            if (rq_stall && !(mem_req_valid_o === 1'b1 && mem_req_addr_o === stall_addr))
                stall_viol++;
        end
        dv_stall   = data_valid_o && !data_ready_i;
        stall_hd   = highdim_data_o;
        stall_ld   = lowdim_data_o;
        rq_stall   = mem_req_valid_o && !mem_req_ready_i;
        stall_addr = mem_req_addr_o;
        if (done_o) begin
            done_cnt++;
            if (prev_done) dbl_done++;
        end
        prev_done = done_o;
        cyc++;
    end

    // Memory: in-order responses, one per cycle, each no earlier than its due cycle.
    int rsp_idx = 0;
    always @(negedge clk) begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        if (rsp_idx < req_q.size() && due_q[rsp_idx] <= cyc) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(req_q[rsp_idx], ovr_q[rsp_idx]);
            rsp_idx++;
        end
    end

    always @(negedge clk) begin
        case (rq_mode)
            0:       mem_req_ready_i = 1'b0;
            1:       mem_req_ready_i = 1'b1;
            default: mem_req_ready_i = 1'($urandom_range(0, 1));
        endcase
        case (dr_mode)
            0:       data_ready_i = 1'b0;
            1:       data_ready_i = 1'b1;
            default: data_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Start pulse, then scramble cfg to prove it was latched.
    task automatic do_start(input logic [31:0] base, input logic [15:0] num, input bit hd,
                            output int rb, output int ob, output int db);
        @(negedge clk);
        rb = req_q.size(); ob = hd_q.size(); db = done_cnt;
        cfg_base_addr_i = base; cfg_num_items_i = num; cfg_highdim_i = hd;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cfg_base_addr_i = $urandom;
        cfg_num_items_i = 16'($urandom_range(0, 40));
        cfg_highdim_i   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int db, input int budget);
        int n = 0;
        while (done_cnt == db && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done_cnt == db), 32'd0);
    endtask

    // Expected stream: request k at base + k*64, data is the memory word there.
    task automatic check_stream(input string tag, input logic [31:0] base, input int num,
                                input int rb, input int ob, input int db);
        logic [31:0]  a;
        logic [511:0] w;
        chk({tag, "_nreq"}, 32'(req_q.size() - rb), 32'(num));
        chk({tag, "_nbeat"}, 32'(hd_q.size() - ob), 32'(num));
        for (int k = 0; k < num; k++) begin
            a = base + 32'(k) * 32'd64;
            w = mem_word(a, ovr_en);
            if (rb + k < req_q.size()) chk($sformatf("%s_addr%0d", tag, k), req_q[rb + k], a);
            if (ob + k < hd_q.size()) begin
                chk_vec($sformatf("%s_hd%0d", tag, k), hd_q[ob + k], w);
                chk($sformatf("%s_ld%0d", tag, k), 32'(ld_q[ob + k]), 32'(w[9:0]));
            end
        end
        chk({tag, "_ndone"}, 32'(done_cnt - db), 32'd1);
        chk({tag, "_dbl_done"}, 32'(dbl_done), 32'd0);
        chk({tag, "_stable"}, 32'(stall_viol), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    int rb, ob, db, num;
    logic [31:0] base;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; clr_i = 1'b0; cfg_highdim_i = 1'b1;
        cfg_base_addr_i = '0; cfg_num_items_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_reqv", 32'(mem_req_valid_o), 32'd0);
        chk("rst_dv", 32'(data_valid_o), 32'd0);
        chk("rst_addr", mem_req_addr_o, 32'd0);
        chk("rst_ld", 32'(lowdim_data_o), 32'd0);
        chk_vec("rst_hd", highdim_data_o, '0);
        rst_i = 1'b0;
        @(negedge clk);

        // Basic 4-item stream, 1-cycle memory.
        do_start(32'h1000, 16'd4, 1'b1, rb, ob, db);
        chk("t1_busy", 32'(busy_o), 32'd1);
        wait_done(db, 200);
        check_stream("t1", 32'h1000, 4, rb, ob, db);

        // Consumer stalled: only BufDepth reads may be outstanding.
        dr_mode = 0;
        do_start(32'h8000, 16'd5, 1'b1, rb, ob, db);
        repeat (10) @(negedge clk);
        chk("t2_nreq_stall", 32'(req_q.size() - rb), 32'd2);
        chk("t2_nbeat_stall", 32'(hd_q.size() - ob), 32'd0);
        chk("t2_dv_stall", 32'(data_valid_o), 32'd1);
        chk_vec("t2_head", highdim_data_o, mem_word(32'h8000, 1'b0));
        dr_mode = 1;
        wait_done(db, 200);
        check_stream("t2", 32'h8000, 5, rb, ob, db);

        // Zero-length stream.
        do_start(32'h5000, 16'd0, 1'b1, rb, ob, db);
        chk("t3_done", 32'(done_o), 32'd1);
        chk("t3_busy", 32'(busy_o), 32'd0);
        chk("t3_reqv", 32'(mem_req_valid_o), 32'd0);
        @(negedge clk);
        chk("t3_done_off", 32'(done_o), 32'd0);
        chk("t3_nreq", 32'(req_q.size() - rb), 32'd0);
        chk("t3_busy2", 32'(busy_o), 32'd0);

        // Clear with two reads in flight; late beats must vanish.
        lat = 8;
        do_start(32'h2000, 16'd4, 1'b1, rb, ob, db);
        for (int n = 0; n < 30 && req_q.size() - rb < 2; n++) @(negedge clk);
        chk("t4_inflight", 32'(req_q.size() - rb), 32'd2);
        chk("t4_dv_pre", 32'(data_valid_o), 32'd0);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("t4_busy_clr", 32'(busy_o), 32'd0);
        repeat (12) @(negedge clk);
        chk("t4_nbeat", 32'(hd_q.size() - ob), 32'd0);
        chk("t4_nreq", 32'(req_q.size() - rb), 32'd2);
        chk("t4_no_done", 32'(done_cnt - db), 32'd0);
        lat = 1;
        do_start(32'h3000, 16'd1, 1'b1, rb, ob, db);
        wait_done(db, 100);
        check_stream("t4b", 32'h3000, 1, rb, ob, db);

        // Low-dim view of a word carrying 0xABC.
        ovr_en = 1'b1;
        do_start(32'h4000, 16'd1, 1'b0, rb, ob, db);
        wait_done(db, 100);
        if (ob < ld_q.size()) chk("t5_lowdim", 32'(ld_q[ob]), 32'h2BC);
        else chk("t5_lowdim_missing", 32'(ld_q.size()), 32'(ob + 1));
        check_stream("t5", 32'h4000, 1, rb, ob, db);
        ovr_en = 1'b0;

        // Address wrap.
        do_start(32'hFFFF_FFC0, 16'd2, 1'b1, rb, ob, db);
        wait_done(db, 100);
        check_stream("t6", 32'hFFFF_FFC0, 2, rb, ob, db);

        // Reset mid-stream: everything quiet, stale beats ignored.
        lat = 3;
        do_start(32'h6000, 16'd6, 1'b1, rb, ob, db);
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_busy", 32'(busy_o), 32'd0);
        chk("t7_reqv", 32'(mem_req_valid_o), 32'd0);
        chk("t7_dv", 32'(data_valid_o), 32'd0);
        rst_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("t7_dv_after", 32'(data_valid_o), 32'd0);
        chk("t7_no_done", 32'(done_cnt - db), 32'd0);

        // Randomized streams with random backpressure and latency.
        rq_mode = 2; dr_mode = 2;
        for (int it = 0; it < 6; it++) begin
            lat  = $urandom_range(1, 4);
            base = $urandom;
            num  = $urandom_range(1, 7);
            do_start(base, 16'(num), 1'($urandom_range(0, 1)), rb, ob, db);
            repeat (2) @(negedge clk);
            if (busy_o) begin
                cfg_base_addr_i = $urandom; cfg_num_items_i = 16'($urandom_range(1, 9));
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
            wait_done(db, 400);
            check_stream($sformatf("rnd%0d", it), base, num, rb, ob, db);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/im_data_fetcher.md
IM_DATA_FETCHER -- requirements
Module: im_data_fetcher

Interface
REQ-001 SHALL have parameter HVDimension, default 512: hypervector width and memory response width in bits.
REQ-002 SHALL have parameter ImAddrWidth, default 10: width of the low-dim item address.
REQ-003 SHALL have parameter MemAddrWidth, default 32: byte address width of the memory port.
REQ-004 SHALL have parameter BufDepth, default 2: response buffer entries, equal to the maximum number of requests in flight.
REQ-005 SHALL have parameter CntWidth, default 16: width of the item counter.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports cfg_base_addr_i, input, MemAddrWidth bits, and cfg_num_items_i, input, CntWidth bits: stream start byte address and item count.
REQ-009 SHALL have port cfg_highdim_i, input, 1 bit: 1 means each word is a full hypervector; 0 means a low-dim address in bits [ImAddrWidth-1:0].
REQ-010 SHALL have ports start_i, input, 1 bit, and clr_i, input, 1 bit: start pulse and software synchronous clear.
REQ-011 SHALL have ports busy_o, output, 1 bit, and done_o, output, 1 bit: busy status and one-cycle completion pulse.
REQ-012 SHALL have ports mem_req_addr_o, output, MemAddrWidth bits; mem_req_valid_o, output, 1 bit; mem_req_ready_i, input, 1 bit: memory read request channel.
REQ-013 SHALL have ports mem_rsp_data_i, input, HVDimension bits, and mem_rsp_valid_i, input, 1 bit: in-order read response channel with no backpressure.
REQ-014 SHALL have ports lowdim_data_o, output, ImAddrWidth bits; highdim_data_o, output, HVDimension bits; data_valid_o, output, 1 bit; data_ready_i, input, 1 bit: stream toward the item memory.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH and DRAIN.
REQ-016 SHALL latch cfg_* on start_i in IDLE; start_i outside IDLE SHALL be ignored; cfg_* changes after the latch SHALL have no effect on the running stream.
REQ-017 SHALL move IDLE->FETCH on start_i when cfg_num_items_i>0; when cfg_num_items_i==0 it SHALL stay in IDLE, issue no requests, and pulse done_o in the next cycle.
REQ-018 SHALL hold mem_req_valid_o high in FETCH only while (inflight + buf_count) < BufDepth, using registered counts with no same-cycle credit return.
REQ-019 SHALL give request k (from 0) the address base + k*(HVDimension/8); addition wraps modulo 2^MemAddrWidth.
REQ-020 SHALL hold mem_req_addr_o and mem_req_valid_o stable until mem_req_ready_i is sampled high.
REQ-021 SHALL move FETCH->DRAIN on the handshake of the last request.
REQ-022 SHALL write each mem_rsp_valid_i beat into the buffer, decrementing inflight; the buffer SHALL never overflow by construction.
REQ-023 SHALL drive data_valid_o high whenever buf_count>0, with the buffer head on the outputs, lowdim_data_o = head[ImAddrWidth-1:0], highdim_data_o = head.
REQ-024 SHALL make a response visible on the outputs no earlier than the cycle after its arrival (no fall-through).
REQ-025 SHALL support a buffer write and read (data_valid_o && data_ready_i) in the same cycle, leaving buf_count unchanged.
REQ-026 SHALL hold the outputs stable while data_valid_o && !data_ready_i.
REQ-027 SHALL move DRAIN->IDLE and pulse done_o for one cycle, in the cycle after the output handshake of the last item.
REQ-028 SHALL drive busy_o high exactly when the state is not IDLE.
REQ-029 SHALL, on clr_i, go to IDLE, empty the buffer and zero the issue/delivery counters in the next cycle, suppress done_o, and load discard_cnt with the current inflight count.
REQ-030 SHALL drop any response arriving while discard_cnt>0, decrementing discard_cnt, and SHALL block a new start_i until discard_cnt==0.
REQ-031 SHALL give clr_i priority over start_i and over any handshake in the same cycle.

Reset
REQ-032 SHALL, on rst_i high at a clock edge, go to IDLE and zero all counters (including inflight and discard_cnt) and the buffer pointers.
REQ-033 SHALL drive busy_o, done_o, mem_req_valid_o and data_valid_o to 0 and mem_req_addr_o, lowdim_data_o and highdim_data_o to 0 during reset.
REQ-034 SHALL apply reset in the same way when asserted mid-stream; memory responses still in flight after reset are not tracked.

Verification
REQ-035 SHALL cover: base=0x1000, num=4, ready tied high, 1-cycle memory -> requests to 0x1000, 0x1040, 0x1080, 0x10C0; 4 output beats in order; done_o single pulse.
REQ-036 SHALL cover: num=5, data_ready_i low for 10 cycles -> at most 2 requests issued, outputs held stable, all 5 beats then delivered in order.
REQ-037 SHALL cover: num=0 -> no mem_req_valid_o, done_o one cycle after start, busy_o stays 0.
REQ-038 SHALL cover: clr_i with 2 requests in flight -> both late responses dropped, data_valid_o stays 0, next start of num=1 delivers only the new word.
REQ-039 SHALL cover: cfg_highdim_i=0, response 0xABC in low bits -> lowdim_data_o=10'h2BC with ImAddrWidth=10.
REQ-040 SHALL cover: base=0xFFFFFFC0, num=2 -> second request to address 0x00000000.
